// File: rtl/ifu_sram_responder_if.sv
// ifu_sram_responder_if: fetch read channel (AR request, R response) between the fetch stage and the SRAM responder
interface ifu_sram_responder_if;
  logic [31:0] araddr_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i;
  modport slave (input araddr_i, arvalid_i, rready_i, output arready_o, rdata_o, rresp_o, rvalid_o);
  modport master(output araddr_i, arvalid_i, rready_i, input arready_o, rdata_o, rresp_o, rvalid_o);
endinterface

// File: rtl/ifu_sram_responder.sv
// ifu_sram_responder: instruction-fetch read slave in front of a synchronous single-port SRAM.
// Ports: clock/reset (async active-low); ar = fetch AR/R channel (slave modport);
// mem_en_o/mem_addr_o/mem_rdata_i = SRAM read port; resp_cnt_o = completed R handshakes.
// RESP_CNT_INIT is the counter value restored by reset (0 in normal use).
module ifu_sram_responder #(
  parameter logic [31:0] ADDR_BASE     = 32'h8000_0000,
  parameter int unsigned MEM_WORDS     = 4096,
  parameter int unsigned LATENCY       = 2,
  parameter logic [31:0] RESP_CNT_INIT = 32'h0,
  localparam int unsigned AW           = $clog2(MEM_WORDS)
) (
  input  logic                 clock,
  input  logic                 reset,
  ifu_sram_responder_if.slave  ar,
  output logic                 mem_en_o,
  output logic [AW-1:0]        mem_addr_o,
  input  logic [31:0]          mem_rdata_i,
  output logic [31:0]          resp_cnt_o
);
  typedef enum logic [2:0] {IDLE, DELAY, ISSUE, CAPT, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] resp_cnt_q, resp_cnt_d;
  logic [31:0] offset;
  logic        misaligned, out_of_range;
  // Offset wraps modulo 2^32, so addresses below the base land far out of range.
  assign offset       = ar.araddr_i - ADDR_BASE;
  assign misaligned   = ar.araddr_i[1:0] != 2'b00;
  assign out_of_range = offset >= 32'(MEM_WORDS * 4);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    resp_cnt_d = resp_cnt_q;
    unique case (state_q)
      IDLE: if (ar.arvalid_i) begin
        if (misaligned || out_of_range) begin
          state_d = RESP;
          rresp_d = misaligned ? 2'b10 : 2'b11;
          rdata_d = '0;
        end else begin
          addr_d  = offset[2 +: AW];
          cnt_d   = 4'(LATENCY);
          state_d = LATENCY == 0 ? ISSUE : DELAY;
        end
      end
      // Leave on the edge that takes the counter from 1 to 0.
      DELAY: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? ISSUE : DELAY;
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        rdata_d = mem_rdata_i;
        rresp_d = 2'b00;
        state_d = RESP;
      end
      RESP: if (ar.rready_i) begin
        resp_cnt_d = resp_cnt_q + 32'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      resp_cnt_q <= RESP_CNT_INIT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end
  assign ar.arready_o = state_q == IDLE;
  assign ar.rvalid_o  = state_q == RESP;
  assign ar.rdata_o   = rdata_q;
  assign ar.rresp_o   = rresp_q;
  assign mem_en_o     = state_q == ISSUE;
  assign mem_addr_o   = addr_q;
  assign resp_cnt_o   = resp_cnt_q;
endmodule

// File: tb/tb_ifu_sram_responder.sv
// tb_ifu_sram_responder: two responders (LATENCY 2 and LATENCY 0 with a preloaded counter) driven with identical requests
module tb_ifu_sram_responder;
  localparam int AW = 12;
  localparam int MW = 4096;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mem [MW];
  logic [31:0] addr = '0;
  logic rready = 1'b1;
  bit rnd = 0;
  int req_id = 0;
  typedef struct {
    logic [31:0]   data;
    logic [1:0]    resp;
    logic [AW-1:0] idx;
    int            acc;
    int            due;
    bit            ok;
  } exp_t;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction
  // Expected response for a request accepted so that cyc==acc just after the accept edge.
  function automatic exp_t predict(input logic [31:0] a, input int acc, input int lat);
    exp_t e;
    logic [31:0] off;
    off = a - BASE;
    e.acc = acc; e.ok = 0; e.data = '0; e.idx = '0; e.due = acc;
    if (a % 4 != 0) e.resp = 2'b10;
    else if (off >= MW * 4) e.resp = 2'b11;
    else begin
      e.ok = 1; e.resp = 2'b00; e.idx = AW'(off / 4); e.data = mem[off / 4]; e.due = acc + lat + 2;
    end
    return e;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = g == 0 ? 2 : 0;
    localparam logic [31:0] INIT = g == 0 ? 32'h0 : 32'hFFFF_FFFF;
    ifu_sram_responder_if bus();
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic [31:0]   resp_cnt;
    logic [31:0]   exp_cnt = INIT;
    exp_t          q[$];
    int            taken = 0;
    bit            idle;
    ifu_sram_responder #(.LATENCY(LAT), .RESP_CNT_INIT(INIT)) dut (
      .clock(clk), .reset(reset), .ar(bus), .mem_en_o(mem_en), .mem_addr_o(mem_addr),
      .mem_rdata_i(mem_rdata), .resp_cnt_o(resp_cnt));
    assign bus.araddr_i  = addr;
    assign bus.arvalid_i = taken != req_id;
    assign bus.rready_i  = rready;
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];
    always @(posedge clk) if (reset && bus.arvalid_i && bus.arready_o) taken <= req_id;
    always @(negedge reset) begin
      #1;
      chk($sformatf("u%0d rst arready", g), bus.arready_o, 1);
      chk($sformatf("u%0d rst rvalid", g), bus.rvalid_o, 0);
      chk($sformatf("u%0d rst rdata", g), bus.rdata_o, 0);
      chk($sformatf("u%0d rst rresp", g), bus.rresp_o, 0);
      chk($sformatf("u%0d rst mem_en", g), mem_en, 0);
      chk($sformatf("u%0d rst mem_addr", g), mem_addr, 0);
      chk($sformatf("u%0d rst resp_cnt", g), resp_cnt, INIT);
    end
    always @(negedge clk) begin
      #2;
      if (!reset) begin
        q.delete();
        exp_cnt = INIT;
      end else begin
        idle = q.size() == 0;
        chk($sformatf("u%0d arready", g), bus.arready_o, idle);
        chk($sformatf("u%0d resp_cnt", g), resp_cnt, exp_cnt);
        chk($sformatf("u%0d rvalid", g), bus.rvalid_o, !idle && cyc >= q[0].due);
        chk($sformatf("u%0d mem_en", g), mem_en, !idle && q[0].ok && cyc == q[0].acc + LAT);
        if (!idle && q[0].ok) chk($sformatf("u%0d mem_addr", g), mem_addr, q[0].idx);
        if (bus.rvalid_o && !idle) begin
          chk($sformatf("u%0d rdata", g), bus.rdata_o, q[0].data);
          chk($sformatf("u%0d rresp", g), bus.rresp_o, q[0].resp);
        end
        if (!idle && cyc >= q[0].due && rready) begin
          q.delete(0);
          exp_cnt++;
        end
        if (bus.arvalid_i && idle) q.push_back(predict(addr, cyc + 1, LAT));
      end
    end
  end
  function automatic bit all_taken();
    return u[0].taken == req_id && u[1].taken == req_id;
  endfunction
  task automatic step();
    @(negedge clk);
    if (rnd) rready = 1'($urandom_range(0, 1));
  endtask
  task automatic issue(input logic [31:0] a);
    int i;
    @(negedge clk);
    addr = a;
    req_id++;
    for (i = 0; i < 300 && !all_taken(); i++) step();
    chk("accept_timeout", i < 300, 1);
  endtask
  task automatic drain();
    int i;
    for (i = 0; i < 300 && !(all_taken() && u[0].q.size() == 0 && u[1].q.size() == 0); i++) step();
    chk("drain_timeout", i < 300, 1);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    logic [31:0] a;
    int r;
    for (int i = 0; i < MW; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0413;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    issue(BASE);
    drain();
    issue(BASE + 32'h2);
    issue(BASE + 32'h4000);
    issue(32'h7FFF_FFFC);
    issue(BASE + 32'h3FFC);
    drain();
    rready = 1'b0;
    issue(BASE + 32'h8);
    @(negedge clk);
    addr = BASE + 32'hC;
    req_id++;
    repeat (8) @(negedge clk);
    rready = 1'b1;
    drain();
    for (int i = 0; i < 10; i++) issue(BASE + 32'(4 * (i + 16)));
    drain();
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = BASE + 32'(4 * $urandom_range(0, MW - 1));
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 1) a = $urandom & ~32'h3;
      if (r == 2) a = BASE + 32'(MW * 4) + 32'(4 * $urandom_range(0, 255));
      issue(a);
    end
    drain();
    rnd = 0;
    rready = 1'b1;
    issue(BASE + 32'h100);
    pulse_reset();
    issue(BASE + 32'h104);
    drain();
    rready = 1'b0;
    issue(BASE + 32'h108);
    repeat (6) @(negedge clk);
    pulse_reset();
    rready = 1'b1;
    issue(BASE + 32'h10C);
    drain();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
